// File: rtl/aes_round_ctrl_if.sv
// Block-input, round-datapath and result signals of the AES round sequencer.
// The decrypt sideband (dec/dec_mode) exists only when AES_ROUND_CTRL_DECRYPT_EN is defined.
interface aes_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_text;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic [127:0] rd_state;
  logic         rd_last;
  logic [127:0] rd_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_text;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
  logic         dec;
  logic         dec_mode;
`endif

  modport master (
    input  in_valid, in_text, rk_data, rd_result, out_ready,
    output in_ready, rk_idx, rd_state, rd_last, out_valid, out_text
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    , input dec, output dec_mode
`endif
  );

  modport slave (
    output in_valid, in_text, rk_data, rd_result, out_ready,
    input  in_ready, rk_idx, rd_state, rd_last, out_valid, out_text
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    , output dec, input dec_mode
`endif
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: one block in flight, NR*ROUND_LAT cycles accept-to-valid, result held until out_ready.
// AES_ROUND_CTRL_DECRYPT_EN adds dec/dec_mode and the inverse (NR..0) round-key order.
module aes_round_ctrl #(
  parameter int NR        = 10,
  parameter int ROUND_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_round_ctrl_if.master bus
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_ctrl: NR must be 10, 12 or 14");
  end
  if (ROUND_LAT < 1 || ROUND_LAT > 15) begin : g_bad_lat
    $error("aes_round_ctrl: ROUND_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } st_t;

  localparam logic [3:0] NR_IDX   = 4'(NR);
  localparam logic [3:0] LAT_LAST = 4'(ROUND_LAT - 1);

  st_t          st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   lat_cnt_q, lat_cnt_d;
  logic [3:0]   rk_idx;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
  logic         dec_q, dec_d;
`endif

  // Key index is a pure decode of state so it stays put for every cycle of a multicycle round.
  always_comb begin
    rk_idx = 4'd0;
    if (st_q == ROUND) begin
      rk_idx = rnd_q;
    end
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    if (st_q == IDLE && bus.dec) begin
      rk_idx = NR_IDX;
    end else if (st_q == ROUND && dec_q) begin
      rk_idx = NR_IDX - rnd_q;
    end
`endif
  end

  assign bus.in_ready  = (st_q == IDLE);
  assign bus.out_valid = (st_q == DONE);
  assign bus.out_text  = state_q;
  assign bus.rd_state  = state_q;
  assign bus.rk_idx    = rk_idx;
  // Last round is rnd==NR in both directions (decrypt then has rk_idx==0).
  assign bus.rd_last   = (st_q == ROUND) && (rnd_q == NR_IDX);
`ifdef AES_ROUND_CTRL_DECRYPT_EN
  assign bus.dec_mode  = dec_q;
`endif

  always_comb begin
    st_d      = st_q;
    state_d   = state_q;
    rnd_d     = rnd_q;
    lat_cnt_d = lat_cnt_q;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    dec_d     = dec_q;
`endif
    case (st_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d   = bus.in_text ^ bus.rk_data;
          rnd_d     = 4'd1;
          lat_cnt_d = 4'd0;
          st_d      = ROUND;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
          dec_d     = bus.dec;
`endif
        end
      end
      ROUND: begin
        lat_cnt_d = lat_cnt_q + 4'd1;
        if (lat_cnt_q == LAT_LAST) begin
          state_d   = bus.rd_result;
          lat_cnt_d = 4'd0;
          if (rnd_q == NR_IDX) begin
            st_d = DONE;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      state_q   <= '0;
      rnd_q     <= '0;
      lat_cnt_q <= '0;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
      dec_q     <= 1'b0;
`endif
    end else begin
      st_q      <= st_d;
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      lat_cnt_q <= lat_cnt_d;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
      dec_q     <= dec_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: two instances (NR=10/LAT=1, NR=14/LAT=3) driving a bench AES round datapath and key store.
module tb_aes_round_ctrl;
  typedef logic [15:0][127:0] ks_t;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [7:0] sbox [256];
  ks_t  ks0, ks1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes_round_ctrl_if b0 ();
  aes_round_ctrl_if b1 ();

  aes_round_ctrl #(.NR(10), .ROUND_LAT(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  aes_round_ctrl #(.NR(14), .ROUND_LAT(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] m0, m1, m2, m3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) b[rr+4*c] = a[rr + 4*((c+rr)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        m0 = b[4*c]; m1 = b[4*c+1]; m2 = b[4*c+2]; m3 = b[4*c+3];
        b[4*c]   = xt(m0) ^ xt(m1) ^ m1 ^ m2 ^ m3;
        b[4*c+1] = m0 ^ xt(m1) ^ xt(m2) ^ m2 ^ m3;
        b[4*c+2] = m0 ^ m1 ^ xt(m2) ^ xt(m3) ^ m3;
        b[4*c+3] = xt(m0) ^ m0 ^ m1 ^ m2 ^ xt(m3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ k;
  endfunction

  // nk = 4 (key in upper 128 bits) or 8
  function automatic ks_t key_exp(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    ks_t ks;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    ks = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [255:0] key, input int nk, input logic [127:0] pt);
    ks_t ks;
    logic [127:0] s;
    int nr;
    nr = nk + 6;
    ks = key_exp(key, nk);
    s = pt ^ ks[0];
    for (int r = 1; r <= nr; r++) s = aes_round(s, ks[r], r == nr);
    return s;
  endfunction

  // Key store and combinational round datapath seen by each controller
  assign b0.rk_data   = ks0[b0.rk_idx];
  assign b0.rd_result = aes_round(b0.rd_state, b0.rk_data, b0.rd_last);
  assign b1.rk_data   = ks1[b1.rk_idx];
  assign b1.rd_result = aes_round(b1.rd_state, b1.rk_data, b1.rd_last);

  // ---------------- bench helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [127:0] t, input logic ordy);
    if (sel == 0) begin
      b0.in_valid = v; b0.in_text = t; b0.out_ready = ordy;
    end else begin
      b1.in_valid = v; b1.in_text = t; b1.out_ready = ordy;
    end
  endtask

  task automatic sample(input int sel, output logic ov, output logic ir, output logic rl,
                        output logic [3:0] rk, output logic [127:0] ot, output logic [127:0] rs);
    if (sel == 0) begin
      ov = b0.out_valid; ir = b0.in_ready; rl = b0.rd_last;
      rk = b0.rk_idx; ot = b0.out_text; rs = b0.rd_state;
    end else begin
      ov = b1.out_valid; ir = b1.in_ready; rl = b1.rd_last;
      rk = b1.rk_idx; ot = b1.out_text; rs = b1.rd_state;
    end
  endtask

  function automatic logic [127:0] junk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One block: accept, check key-index/last-round windows and latency, optional backpressure, release.
  task automatic run_block(input int sel, input logic [127:0] pt, input logic [127:0] exp,
                           input int nr, input int lat, input int hold, input string tag);
    logic ov, ir, rl;
    logic [3:0] rk;
    logic [127:0] ot, rs;
    @(negedge clk);
    sample(sel, ov, ir, rl, rk, ot, rs);
    chk({tag, "_idle_rdy"}, 128'(ir), 128'(1));
    chk({tag, "_idle_rk"},  128'(rk), 128'(0));
    drive(sel, 1'b1, pt, hold == 0);
    @(negedge clk);
    drive(sel, 1'b0, junk(), hold == 0);
    for (int k = 0; k < nr*lat; k++) begin
      sample(sel, ov, ir, rl, rk, ot, rs);
      chk($sformatf("%s_rk%0d", tag, k),   128'(rk), 128'(1 + k/lat));
      chk($sformatf("%s_last%0d", tag, k), 128'(rl), 128'((k/lat) == nr-1));
      chk($sformatf("%s_busy%0d", tag, k), 128'({ov, ir}), 128'(0));
      @(negedge clk);
    end
    sample(sel, ov, ir, rl, rk, ot, rs);
    chk({tag, "_vld"}, 128'(ov), 128'(1));
    chk({tag, "_ct"},  ot, exp);
    for (int h = 0; h < hold; h++) begin
      drive(sel, (h % 2) == 0, junk(), 1'b0);
      @(negedge clk);
      sample(sel, ov, ir, rl, rk, ot, rs);
      chk($sformatf("%s_hold_vld%0d", tag, h), 128'(ov), 128'(1));
      chk($sformatf("%s_hold_rdy%0d", tag, h), 128'(ir), 128'(0));
      chk($sformatf("%s_hold_ct%0d", tag, h),  ot, exp);
    end
    drive(sel, 1'b0, junk(), 1'b1);
    @(negedge clk);
    sample(sel, ov, ir, rl, rk, ot, rs);
    chk({tag, "_rel_vld"}, 128'(ov), 128'(0));
    chk({tag, "_rel_rdy"}, 128'(ir), 128'(1));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic ov, ir, rl, found;
    logic [3:0] rk;
    logic [127:0] ot, rs, pt, exp;
    logic [255:0] key;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(0, 1'b0, '0, 1'b1);
    drive(1, 1'b0, '0, 1'b1);
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    b0.dec = 1'b0;
    b1.dec = 1'b0;
`endif
    build_sbox();
    ks0 = key_exp({KEY128, 128'h0}, 4);
    ks1 = key_exp(KEY256, 8);

    #12;
    for (int s = 0; s < 2; s++) begin
      sample(s, ov, ir, rl, rk, ot, rs);
      chk($sformatf("rst%0d_vld", s),  128'(ov), 128'(0));
      chk($sformatf("rst%0d_rdy", s),  128'(ir), 128'(1));
      chk($sformatf("rst%0d_rk", s),   128'(rk), 128'(0));
      chk($sformatf("rst%0d_last", s), 128'(rl), 128'(0));
      chk($sformatf("rst%0d_ot", s),   ot, 128'(0));
      chk($sformatf("rst%0d_rs", s),   rs, 128'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_block(0, PT, CT128, 10, 1, 0, "fips128");
    run_block(0, PT, CT128, 10, 1, 5, "bp_first");
    run_block(0, PT, CT128, 10, 1, 0, "bp_second");

    // Asynchronous reset in the middle of round 5
    @(negedge clk);
    drive(0, 1'b1, PT, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, junk(), 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      sample(0, ov, ir, rl, rk, ot, rs);
      if (rk == 4'd5) found = 1'b1;
      else @(negedge clk);
    end
    chk("mid_rst_reach_rk5", 128'(found), 128'(1));
    #2 rst_n = 1'b0;
    #1 sample(0, ov, ir, rl, rk, ot, rs);
    chk("mid_rst_vld", 128'(ov), 128'(0));
    chk("mid_rst_rk",  128'(rk), 128'(0));
    chk("mid_rst_rs",  rs, 128'(0));
    chk("mid_rst_rdy", 128'(ir), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    run_block(0, PT, CT128, 10, 1, 0, "after_rst");

    run_block(1, PT, CT256, 14, 3, 0, "fips256");

    for (int n = 0; n < 4; n++) begin
      key = {junk(), 128'h0};
      pt  = junk();
      ks0 = key_exp(key, 4);
      exp = aes_enc(key, 4, pt);
      run_block(0, pt, exp, 10, 1, $urandom_range(0, 3), $sformatf("rand128_%0d", n));
    end
    for (int n = 0; n < 2; n++) begin
      key = {junk(), junk()};
      pt  = junk();
      ks1 = key_exp(key, 8);
      exp = aes_enc(key, 8, pt);
      run_block(1, pt, exp, 14, 3, $urandom_range(0, 3), $sformatf("rand256_%0d", n));
    end

`ifdef AES_ROUND_CTRL_DECRYPT_EN
    chk("enc_dec_mode", 128'(b0.dec_mode), 128'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
